// File: rtl/aes_128_iter_core.sv
// Iterative AES-128 encrypt/decrypt core with an optional key-schedule cache; one block in flight.
// Latency 11+10/R cycles with key expansion, 1+10/R on a cache hit; result held in DONE until out_ready.
module aes_128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int KEY_CACHE        = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_mode,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rpc
    $error("aes_128_iter_core: ROUNDS_PER_CYCLE must be 1, 2 or 5");
  end

  typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, ROUND, DONE} state_t;

  localparam logic [3:0] R_STEP = 4'(ROUNDS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via a short addition chain (0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    a252 = gmul(a240, a12);
    return gmul(a252, a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    if (inv)
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the block sits at row i%4, column i/4, bits [127-8i -: 8].
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    if (!last)
      for (int c = 0; c < 4; c++) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32], 1'b0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    t = t ^ k;
    if (!last)
      for (int c = 0; c < 4; c++) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32], 1'b1);
    return t;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state;
  logic [3:0]   kcnt;
  logic [3:0]   rnd;
  logic         mode_q;
  logic         cache_vld;
  logic [127:0] blk;
  logic [127:0] rk [0:10];

  logic         key_miss;
  logic [127:0] key_prev;
  logic [31:0]  key_t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] key_nxt;
  logic [127:0] round_nxt;
  logic [3:0]   rnd_idx;

  // rk[0] doubles as the cached key, so a hit needs no separate key register.
  assign key_miss = (KEY_CACHE == 0) || !cache_vld || (in_key != rk[0]);

  always_comb begin
    key_prev = rk[kcnt - 4'd1];
    key_t    = {sbox(key_prev[23:16]), sbox(key_prev[15:8]), sbox(key_prev[7:0]),
                sbox(key_prev[31:24])} ^ {rcon(kcnt), 24'h0};
    n0       = key_prev[127:96] ^ key_t;
    n1       = key_prev[95:64] ^ n0;
    n2       = key_prev[63:32] ^ n1;
    n3       = key_prev[31:0] ^ n2;
    key_nxt  = {n0, n1, n2, n3};
  end

  always_comb begin
    round_nxt = blk;
    rnd_idx   = rnd;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd_idx = rnd + 4'(j + 1);
      if (mode_q) round_nxt = dec_round(round_nxt, rk[4'd10 - rnd_idx], rnd_idx == 4'd10);
      else        round_nxt = enc_round(round_nxt, rk[rnd_idx], rnd_idx == 4'd10);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && key_miss) rk[0] <= in_key;
    if (state == KEYEXP) rk[kcnt] <= key_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      cache_vld <= 1'b0;
      kcnt      <= '0;
      rnd       <= '0;
      mode_q    <= 1'b0;
      blk       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          blk      <= in_data;
          mode_q   <= in_mode;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (key_miss) begin
            cache_vld <= 1'b0;
            kcnt      <= 4'd1;
            state     <= KEYEXP;
          end else begin
            state <= WHITEN;
          end
        end
        KEYEXP: begin
          kcnt <= kcnt + 4'd1;
          if (kcnt == 4'd10) begin
            cache_vld <= 1'b1;
            state     <= WHITEN;
          end
        end
        WHITEN: begin
          blk   <= blk ^ (mode_q ? rk[10] : rk[0]);
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          blk <= round_nxt;
          rnd <= rnd + R_STEP;
          if (rnd + R_STEP == 4'd10) begin
            out_valid <= 1'b1;
            out_data  <= round_nxt;
            out_mode  <= mode_q;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
